// File: rtl/dualram_fifo_ctrl.sv
// FIFO controller in front of a single-clock dual-port RAM with a registered read port.
// Optional almost_full/almost_empty flags are enabled by defining FIFO_ALMOST_FLAGS_EN.
module dualram_fifo_ctrl #(
    parameter int MEM_WIDTH       = 16,
    parameter int MEM_DEPTH       = 1024,
    parameter int ADDR_SIZE       = 10,
    parameter int ALMOST_FULL_TH  = 1020,
    parameter int ALMOST_EMPTY_TH = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 push_valid_i,
    input  logic [MEM_WIDTH-1:0] push_data_i,
    output logic                 push_ready_o,
    input  logic                 pop_valid_i,
    output logic                 pop_ready_o,
    output logic                 pop_data_valid_o,
    output logic [MEM_WIDTH-1:0] pop_data_o,
    output logic [ADDR_SIZE:0]   count_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 almost_full_o,
    output logic                 almost_empty_o,
    output logic [MEM_WIDTH-1:0] ram_din_o,
    output logic [ADDR_SIZE-1:0] ram_addr_wr_o,
    output logic [ADDR_SIZE-1:0] ram_addr_rd_o,
    output logic                 ram_wr_en_o,
    output logic                 ram_rd_en_o,
    output logic                 ram_blk_select_o,
    input  logic [MEM_WIDTH-1:0] ram_dout_i
);

    typedef enum logic {GRANT_WRITE = 1'b0, GRANT_READ = 1'b1} grant_e;

    localparam logic [ADDR_SIZE:0] DEPTH_COUNT = (ADDR_SIZE + 1)'(MEM_DEPTH);

    logic [ADDR_SIZE-1:0] wPtr_q, wPtr_d;
    logic [ADDR_SIZE-1:0] rPtr_q, rPtr_d;
    logic [ADDR_SIZE:0]   count_q, count_d;
    grant_e               lastGrant_q, lastGrant_d;
    logic                 popDataValid_q;

    logic full, empty;
    logic wrCand, rdCand;
    logic grantWrite, grantRead;
    logic pushAccept, popAccept;

    assign full  = (count_q == DEPTH_COUNT);
    assign empty = (count_q == '0);

    // The RAM drops a read issued in a write cycle, so at most one side is granted;
    // under contention the side that did not win last time goes next.
    assign wrCand     = push_valid_i & ~full;
    assign rdCand     = pop_valid_i & ~empty;
    assign grantWrite = wrCand & (~rdCand | (lastGrant_q == GRANT_READ));
    assign grantRead  = rdCand & (~wrCand | (lastGrant_q == GRANT_WRITE));
    assign pushAccept = grantWrite & ~rst_i;
    assign popAccept  = grantRead & ~rst_i;

    always_comb begin
        wPtr_d      = wPtr_q;
        rPtr_d      = rPtr_q;
        count_d     = count_q;
        lastGrant_d = lastGrant_q;
        if (pushAccept) begin
            wPtr_d      = wPtr_q + ADDR_SIZE'(1);
            count_d     = count_q + (ADDR_SIZE + 1)'(1);
            lastGrant_d = GRANT_WRITE;
        end else if (popAccept) begin
            rPtr_d      = rPtr_q + ADDR_SIZE'(1);
            count_d     = count_q - (ADDR_SIZE + 1)'(1);
            lastGrant_d = GRANT_READ;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wPtr_q         <= '0;
            rPtr_q         <= '0;
            count_q        <= '0;
            lastGrant_q    <= GRANT_READ;
            popDataValid_q <= 1'b0;
        end else begin
            wPtr_q         <= wPtr_d;
            rPtr_q         <= rPtr_d;
            count_q        <= count_d;
            lastGrant_q    <= lastGrant_d;
            popDataValid_q <= popAccept;
        end
    end

`ifdef FIFO_ALMOST_FLAGS_EN
    logic almostFull_q, almostEmpty_q;

    // Computed from count_d so the flags move on the same edge as count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            almostFull_q  <= 1'b0;
            almostEmpty_q <= 1'b1;
        end else begin
            almostFull_q  <= (count_d >= (ADDR_SIZE + 1)'(ALMOST_FULL_TH));
            almostEmpty_q <= (count_d <= (ADDR_SIZE + 1)'(ALMOST_EMPTY_TH));
        end
    end

    assign almost_full_o  = almostFull_q;
    assign almost_empty_o = almostEmpty_q;
`else
    assign almost_full_o  = 1'b0;
    assign almost_empty_o = 1'b0;
`endif

    assign push_ready_o     = pushAccept;
    assign pop_ready_o      = popAccept;
    assign pop_data_valid_o = popDataValid_q;
    assign pop_data_o       = ram_dout_i;
    assign count_o          = count_q;
    assign full_o           = full;
    assign empty_o          = empty;
    assign ram_din_o        = push_data_i;
    assign ram_addr_wr_o    = wPtr_q;
    assign ram_addr_rd_o    = rPtr_q;
    assign ram_wr_en_o      = pushAccept;
    assign ram_rd_en_o      = popAccept;
    assign ram_blk_select_o = pushAccept | popAccept;

endmodule

// File: tb/tb_dualram_fifo_ctrl.sv
// Directed self-checking bench for dualram_fifo_ctrl at depth 16 with a behavioural RAM.
// Almost-flag expectations follow FIFO_ALMOST_FLAGS_EN when it is defined for the build.
module tb_dualram_fifo_ctrl;

    localparam int W  = 16;
    localparam int D  = 16;
    localparam int A  = 4;
    localparam int AF = 14;
    localparam int AE = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         pushValid;
    logic [W-1:0] pushData;
    logic         pushReady;
    logic         popValid;
    logic         popReady;
    logic         popDataValid;
    logic [W-1:0] popData;
    logic [A:0]   count;
    logic         full, empty, almostFull, almostEmpty;
    logic [W-1:0] ramDin;
    logic [A-1:0] ramAddrWr, ramAddrRd;
    logic         ramWrEn, ramRdEn, ramBlkSelect;
    logic [W-1:0] ramDout;

    logic [W-1:0] ramArray [D];

    int assertCount = 0;
    int failCount   = 0;

    int           expCount    = 0;
    logic [A-1:0] expWptr     = '0;
    logic [A-1:0] expRptr     = '0;
    logic         pendingPop  = 1'b0;
    logic [W-1:0] pendingData = '0;
    logic [W-1:0] fifoModel [$];

    always #5 clk = ~clk;

    dualram_fifo_ctrl #(
        .MEM_WIDTH(W), .MEM_DEPTH(D), .ADDR_SIZE(A),
        .ALMOST_FULL_TH(AF), .ALMOST_EMPTY_TH(AE)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .push_valid_i(pushValid), .push_data_i(pushData), .push_ready_o(pushReady),
        .pop_valid_i(popValid), .pop_ready_o(popReady),
        .pop_data_valid_o(popDataValid), .pop_data_o(popData),
        .count_o(count), .full_o(full), .empty_o(empty),
        .almost_full_o(almostFull), .almost_empty_o(almostEmpty),
        .ram_din_o(ramDin), .ram_addr_wr_o(ramAddrWr), .ram_addr_rd_o(ramAddrRd),
        .ram_wr_en_o(ramWrEn), .ram_rd_en_o(ramRdEn), .ram_blk_select_o(ramBlkSelect),
        .ram_dout_i(ramDout)
    );

    // Behavioural RAM: synchronous write, registered read.
    always @(posedge clk) begin
        if (ramWrEn) ramArray[ramAddrWr] <= ramDin;
        if (ramRdEn) ramDout <= ramArray[ramAddrRd];
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic expAlmostFull(input int c);
`ifdef FIFO_ALMOST_FLAGS_EN
        return (c >= AF);
`else
        return 1'b0;
`endif
    endfunction

    function automatic logic expAlmostEmpty(input int c);
`ifdef FIFO_ALMOST_FLAGS_EN
        return (c <= AE);
`else
        return 1'b0;
`endif
    endfunction

    // One clock cycle: drive inputs, check against the model, advance the model.
    task automatic applyStimulus(input logic pv, input logic [W-1:0] pd, input logic rv,
                                 input logic expPush, input logic expPop);
        @(negedge clk);
        pushValid = pv;
        pushData  = pd;
        popValid  = rv;
        #1;
        checkOutput("count", 32'(count), 32'(expCount));
        checkOutput("full", 32'(full), 32'(expCount == D));
        checkOutput("empty", 32'(empty), 32'(expCount == 0));
        checkOutput("almost_full", 32'(almostFull), 32'(expAlmostFull(expCount)));
        checkOutput("almost_empty", 32'(almostEmpty), 32'(expAlmostEmpty(expCount)));
        checkOutput("push_ready", 32'(pushReady), 32'(expPush));
        checkOutput("pop_ready", 32'(popReady), 32'(expPop));
        checkOutput("ram_wr_en", 32'(ramWrEn), 32'(expPush));
        checkOutput("ram_rd_en", 32'(ramRdEn), 32'(expPop));
        checkOutput("blk_select", 32'(ramBlkSelect), 32'(expPush | expPop));
        checkOutput("ram_addr_wr", 32'(ramAddrWr), 32'(expWptr));
        checkOutput("ram_addr_rd", 32'(ramAddrRd), 32'(expRptr));
        checkOutput("pop_data_valid", 32'(popDataValid), 32'(pendingPop));
        if (pendingPop) checkOutput("pop_data", 32'(popData), 32'(pendingData));
        if (expPush) begin
            fifoModel.push_back(pd);
            expWptr = expWptr + 1'b1;
            expCount++;
        end
        if (expPop) begin
            pendingData = fifoModel.pop_front();
            expRptr = expRptr + 1'b1;
            expCount--;
        end
        pendingPop = expPop;
    endtask

    initial begin
        rst       = 1'b1;
        pushValid = 1'b1;
        pushData  = 16'hDEAD;
        popValid  = 1'b0;
        #3;
        checkOutput("rst_count", 32'(count), 32'd0);
        checkOutput("rst_empty", 32'(empty), 32'd1);
        checkOutput("rst_full", 32'(full), 32'd0);
        checkOutput("rst_pop_data_valid", 32'(popDataValid), 32'd0);
        checkOutput("rst_wr_en", 32'(ramWrEn), 32'd0);
        checkOutput("rst_rd_en", 32'(ramRdEn), 32'd0);
        checkOutput("rst_push_ready", 32'(pushReady), 32'd0);
        checkOutput("rst_almost_empty", 32'(almostEmpty), 32'(expAlmostEmpty(0)));
        @(negedge clk);
        pushValid = 1'b0;
        rst       = 1'b0;

        $display("[TB] fill to full");
        for (int i = 0; i < D; i++) applyStimulus(1'b1, W'(i), 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h0099, 1'b0, 1'b0, 1'b0);

        $display("[TB] drain from full");
        for (int i = 0; i < D; i++) applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        $display("[TB] contention");
        applyStimulus(1'b1, 16'h0100, 1'b1, 1'b1, 1'b0);
        for (int i = 1; i < 6; i++) applyStimulus(1'b1, W'(16'h0100 + i), 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0200, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h0201, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h0202, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b1, 16'h0203, 1'b1, 1'b0, 1'b1);

        $display("[TB] pointer wrap");
        for (int i = 0; i < 40; i++) begin
            applyStimulus(1'b1, W'(16'h0300 + i), 1'b0, 1'b1, 1'b0);
            applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        end

        $display("[TB] reset mid-burst");
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("midrst_pop_data_valid", 32'(popDataValid), 32'd0);
        checkOutput("midrst_count", 32'(count), 32'd0);
        checkOutput("midrst_empty", 32'(empty), 32'd1);
        checkOutput("midrst_rd_en", 32'(ramRdEn), 32'd0);
        checkOutput("midrst_pop_ready", 32'(popReady), 32'd0);
        expCount   = 0;
        expWptr    = '0;
        expRptr    = '0;
        pendingPop = 1'b0;
        fifoModel.delete();
        @(negedge clk);
        checkOutput("midrst_pop_data_valid_next", 32'(popDataValid), 32'd0);
        rst      = 1'b0;
        popValid = 1'b0;
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hABCD, 1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule

// File: doc/dualram_fifo_ctrl.md
# dualram_fifo_ctrl

First-word-fall-through-free FIFO controller that sits directly upstream of the team's single-clock dual-port RAM (write port plus registered read port). It owns the write and read pointers, occupancy count and push/pop handshakes. It drives the RAM's din, addr_wr, addr_rd, wr_en, rd_en and blk_select, and qualifies the RAM's registered dout with a valid strobe. The RAM ignores a read in any cycle it writes, so the controller never issues both in one cycle and arbitrates between push and pop.

## Interface
- MEM_WIDTH, 16, data width; must match the RAM.
- MEM_DEPTH, 1024, RAM depth; must equal 2**ADDR_SIZE.
- ADDR_SIZE, 10, pointer width.
- ALMOST_FULL_TH, 1020, count at or above which almost_full asserts (only when FIFO_ALMOST_FLAGS_EN is defined).
- ALMOST_EMPTY_TH, 4, count at or below which almost_empty asserts (only when FIFO_ALMOST_FLAGS_EN is defined).
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- push_valid  in  1  upstream has a word on push_data.
- push_data  in  MEM_WIDTH  word to store.
- push_ready  out  1  push accepted this cycle when push_valid & push_ready.
- pop_valid  in  1  downstream requests a word.
- pop_ready  out  1  pop accepted this cycle when pop_valid & pop_ready.
- pop_data_valid  out  1  registered; pop_data is valid this cycle.
- pop_data  out  MEM_WIDTH  direct pass-through of ram_dout.
- count  out  ADDR_SIZE+1  current occupancy, 0..MEM_DEPTH.
- full, empty  out  1 each  count==MEM_DEPTH / count==0.
- almost_full, almost_empty  out  1 each  threshold flags (see Configuration).
- ram_din  out  MEM_WIDTH  = push_data.
- ram_addr_wr, ram_addr_rd  out  ADDR_SIZE  = wptr / rptr.
- ram_wr_en, ram_rd_en, ram_blk_select  out  1 each  RAM controls; blk_select = wr_en | rd_en.
- ram_dout  in  MEM_WIDTH  RAM registered read data.

## Operation
- Candidates: wr_cand = push_valid & !full; rd_cand = pop_valid & !empty.
- Grant: only one candidate -> it wins; both -> the side not granted last (last_grant register, reset value = READ, so the first contention goes to WRITE); neither -> idle.
- push_ready = wr_cand & write granted; pop_ready = rd_cand & read granted. Both are combinational; they never assert together.
- ram_wr_en = push accepted; ram_rd_en = pop accepted. Both are combinational, so the RAM acts on the same edge.
- On accepted push: wptr += 1 (mod MEM_DEPTH), count += 1, last_grant <= WRITE.
- On accepted pop: rptr += 1 (mod MEM_DEPTH), count -= 1, last_grant <= READ.
- Count never increments and decrements in the same cycle.
- last_grant updates on every grant, contested or not.
- Pointers wrap naturally at ADDR_SIZE bits. Full/empty derive only from count.
- Full: push_ready = 0 regardless of arbitration. Empty: pop_ready = 0, and a simultaneous push is granted alone.

## Timing
- Push: data is written at the edge ending the accept cycle. Count and flags update at that edge.
- Pop: read is issued at the accept edge. pop_data_valid is high exactly the following cycle, with pop_data = the word.
- Latency, pop accept to data: 1 cycle.
- Push-to-pop: a word pushed in cycle k is poppable in cycle k+1; data arrives in k+2.
- Back-to-back pops sustain 1 word/cycle. Under continuous contention each side gets 1 word per 2 cycles.
- Reset (async, any time) clears wptr, rptr, count, pop_data_valid and almost_full to 0. It sets empty = 1 and almost_empty = 1 (with the macro), full = 0 and last_grant = READ.
- Combinational RAM controls are forced to 0 while rst is high. A read in flight during reset is dropped; no pop_data_valid follows.

## Configuration
- Macro FIFO_ALMOST_FLAGS_EN.
- Defined: almost_full = (count >= ALMOST_FULL_TH); almost_empty = (count <= ALMOST_EMPTY_TH). Both are registered alongside count, so they change on the same edge.
- Undefined: both ports remain and are tied to 0; the threshold parameters are unused.

## Test plan
- Reset with MEM_DEPTH=16, ADDR_SIZE=4 -> count=0, empty=1, full=0, pop_data_valid=0, ram_wr_en=ram_rd_en=0.
- Push 16 words 0x0000..0x000F, pop idle -> full=1 after the 16th edge, count=16, and push_ready=0 on a 17th push_valid.
- Pop 16 from full -> pop_data 0x0000..0x000F in order, each one cycle after its pop_ready; empty=1 at the end; no RAM read issued while empty.
- push_valid and pop_valid both held high with count=5 -> grants alternate W,R,W,R starting with W; ram_wr_en & ram_rd_en never both 1; count oscillates 6,5,6,5.
- 40 push/pop pairs at depth 16 -> pointers wrap twice; data order is preserved; count never exceeds 16.
- rst asserted mid-burst, the cycle after a pop accept -> outputs clear immediately; no pop_data_valid the next cycle.
- With FIFO_ALMOST_FLAGS_EN, ALMOST_FULL_TH=14, ALMOST_EMPTY_TH=2 -> almost_full rises on the edge where count reaches 14; almost_empty falls when count reaches 3.
